spi_slave: RTL and testbench

//  SPI target (slave) endpoint; counterpart of the team's spi_master. Oversamples async sclk/mosi/ss_n in
//  the system clk domain and shifts one DATA_WIDTH word each way per frame. Exposes a 1-deep TX buffer
//  (valid/ready) and an RX word strobe. Sits between the external SPI pins and a local register/CPU block.

---
 rtl/spi_slave.sv | 194 +++++++++++++++++++
 tb/tb_spi_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled sclk/mosi/ss_n, one DATA_WIDTH word each way per frame, 1-deep TX buffer.
// Optional error outputs (frame_err, tx_underrun) are built when SPI_SLAVE_ERR_EN is defined.
module spi_slave #(
    parameter int MODE             = 0,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ACTIVE_LOW = 1,
    parameter int MSB_FIRST        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
`ifdef SPI_SLAVE_ERR_EN
    output logic                  frame_err,
    output logic                  tx_underrun,
`endif
    output logic                  irq
);

    localparam logic CPOL    = (MODE >= 2);
    localparam logic CPHA    = (MODE == 1) || (MODE == 3);
    localparam logic SS_IDLE = (SLAVE_ACTIVE_LOW != 0);
    localparam int   CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t r_state, w_state_next;

    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_ss_s1, r_ss_s2;
    logic r_mosi_s1, r_mosi_s2;

    logic [DATA_WIDTH-1:0] r_tx_shift, r_rx_shift, r_buf, r_rx_data;
    logic                  r_buf_full, r_done, r_miso, r_busy, r_rx_valid;
    logic [CW-1:0]         r_bit_cnt;

    logic w_ss_act, w_lead, w_trail, w_sample, w_shift, w_load, w_abort, w_accept;
    logic [DATA_WIDTH-1:0] w_load_word, w_load_rest, w_tx_rest, w_rx_next;
    logic w_load_bit, w_tx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s1 <= CPOL;
            r_sclk_s2 <= CPOL;
            r_sclk_d  <= CPOL;
            r_ss_s1   <= SS_IDLE;
            r_ss_s2   <= SS_IDLE;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_ss_s1   <= ss_n;
            r_ss_s2   <= r_ss_s1;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_ss_act = (r_ss_s2 != SS_IDLE);
    assign w_lead   = (r_sclk_s2 != r_sclk_d) && (r_sclk_s2 != CPOL);
    assign w_trail  = (r_sclk_s2 != r_sclk_d) && (r_sclk_s2 == CPOL);
    assign w_accept = tx_valid && !r_buf_full;
    assign w_sample = (r_state == S_ACTIVE) && w_ss_act && !r_done && (CPHA ? w_trail : w_lead);
    // CPHA=0: the trail edge right after a reload (bit_cnt==0) must not skip the preloaded first bit.
    assign w_shift  = (r_state == S_ACTIVE) && w_ss_act &&
                      (CPHA ? w_lead : (w_trail && (r_bit_cnt != '0)));

    always_comb begin
        w_load_word = r_buf_full ? r_buf : '0;
        if (MSB_FIRST != 0) begin
            w_load_bit  = w_load_word[DATA_WIDTH-1];
            w_load_rest = {w_load_word[DATA_WIDTH-2:0], 1'b0};
            w_tx_bit    = r_tx_shift[DATA_WIDTH-1];
            w_tx_rest   = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2};
        end else begin
            w_load_bit  = w_load_word[0];
            w_load_rest = {1'b0, w_load_word[DATA_WIDTH-1:1]};
            w_tx_bit    = r_tx_shift[0];
            w_tx_rest   = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
            w_rx_next   = {r_mosi_s2, r_rx_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_act) begin
                    w_state_next = S_ACTIVE;
                    w_load       = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!w_ss_act) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (r_done) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_busy     <= (w_state_next == S_ACTIVE);
            if (w_accept) r_buf <= tx_data;
            r_buf_full <= w_accept ? 1'b1 : (w_load ? 1'b0 : r_buf_full);
            if (r_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_done     <= 1'b0;
            end
            if (w_sample) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + CW'(1);
                if (r_bit_cnt == LAST_BIT) r_done <= 1'b1;
            end
            if (w_shift) begin
                r_miso     <= w_tx_bit;
                r_tx_shift <= w_tx_rest;
            end
            if (w_load) begin
                r_bit_cnt <= '0;
                if (CPHA) begin
                    r_tx_shift <= w_load_word;
                end else begin
                    r_miso     <= w_load_bit;
                    r_tx_shift <= w_load_rest;
                end
            end
            if (w_abort) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            frame_err   <= w_abort && (r_bit_cnt != '0) && (r_bit_cnt != FULL_CNT);
            tx_underrun <= w_load && !r_buf_full;
        end
    end
`else
    // Without error reporting, aborted frames and underruns are silent.
`endif

    assign miso     = r_miso;
    assign miso_oe  = r_busy;
    assign busy     = r_busy;
    assign tx_ready = !r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign irq      = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a MODE0/MSB-first instance and a MODE3/LSB-first instance,
// each driven by a bit-banged master with sclk = clk/16.
module tb_spi_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mosi = 1'b0;
    logic sclk0 = 1'b0, ss0 = 1'b1, sclk3 = 1'b1, ss3 = 1'b1;
    logic miso0, oe0, rdy0, rxv0, busy0, irq0;
    logic miso3, oe3, rdy3, rxv3, busy3, irq3;
    logic [7:0] txd0 = '0, txd3 = '0, rxd0, rxd3;
    logic txv0 = 1'b0, txv3 = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int n_rx0 = 0, n_irq0 = 0, n_rx3 = 0, n_irq3 = 0;
`ifdef SPI_SLAVE_ERR_EN
    logic ferr0, urun0, ferr3, urun3;
    int n_ferr0 = 0, n_urun0 = 0;
`endif

    always #5 clk = ~clk;

    spi_slave #(.MODE(0), .DATA_WIDTH(8), .SLAVE_ACTIVE_LOW(1), .MSB_FIRST(1)) u_m0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .mosi(mosi), .ss_n(ss0),
        .miso(miso0), .miso_oe(oe0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0),
        .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
`ifdef SPI_SLAVE_ERR_EN
        .frame_err(ferr0), .tx_underrun(urun0),
`endif
        .irq(irq0));

    spi_slave #(.MODE(3), .DATA_WIDTH(8), .SLAVE_ACTIVE_LOW(1), .MSB_FIRST(0)) u_m3 (
        .clk(clk), .rst(rst), .sclk(sclk3), .mosi(mosi), .ss_n(ss3),
        .miso(miso3), .miso_oe(oe3), .tx_data(txd3), .tx_valid(txv3), .tx_ready(rdy3),
        .rx_data(rxd3), .rx_valid(rxv3), .busy(busy3),
`ifdef SPI_SLAVE_ERR_EN
        .frame_err(ferr3), .tx_underrun(urun3),
`endif
        .irq(irq3));

    always @(negedge clk) begin
        if (rxv0) n_rx0++;
        if (irq0) n_irq0++;
        if (rxv3) n_rx3++;
        if (irq3) n_irq3++;
`ifdef SPI_SLAVE_ERR_EN
        if (ferr0) n_ferr0++;
        if (urun0) n_urun0++;
`endif
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sclk(input bit d, input logic v);
        if (d) sclk3 = v;
        else   sclk0 = v;
    endtask

    // d=0 drives the MODE0 MSB-first instance, d=1 the MODE3 LSB-first instance.
    task automatic xfer(input bit d, input int nbits, input logic [7:0] wr, output logic [7:0] rd);
        int idx;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = d ? i : 7 - i;
            if (!d) begin
                mosi = wr[idx];
                wait_clk(8);
                rd[idx] = miso0;
                set_sclk(d, 1'b1);
                wait_clk(8);
                set_sclk(d, 1'b0);
            end else begin
                set_sclk(d, 1'b0);
                mosi = wr[idx];
                wait_clk(8);
                rd[idx] = miso3;
                set_sclk(d, 1'b1);
                wait_clk(8);
            end
        end
        if (!d) wait_clk(8);
    endtask

    task automatic push0(input logic [7:0] v);
        txd0 = v; txv0 = 1'b1;
        wait_clk(1);
        txv0 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        n_checks++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso0); end
        n_checks++; if (oe0 !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", oe0); end
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", rdy0); end
        n_checks++; if (rxd0 !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rxd0); end
        n_checks++; if ({rxv0, irq0, busy0} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {rxv0, irq0, busy0}); end
        n_checks++; if ({miso3, oe3, rdy3, busy3} !== 4'b0010) begin n_fail++; $display("FAIL reset_m3 got=%b exp=0010", {miso3, oe3, rdy3, busy3}); end
    endtask

    task automatic test_basic;
        logic [7:0] rd;
        int rx_b, irq_b;
        rx_b = n_rx0; irq_b = n_irq0;
        push0(8'hA5);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_full got=%b exp=0", rdy0); end
        ss0 = 1'b0;
        wait_clk(8);
        n_checks++; if ({busy0, oe0} !== 2'b11) begin n_fail++; $display("FAIL basic_busy got=%b exp=11", {busy0, oe0}); end
        xfer(1'b0, 8, 8'h3C, rd);
        ss0 = 1'b1;
        wait_clk(6);
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL basic_miso got=%h exp=a5", rd); end
        n_checks++; if (rxd0 !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data got=%h exp=3c", rxd0); end
        n_checks++; if (n_rx0 - rx_b !== 1) begin n_fail++; $display("FAIL basic_rx_valid got=%0d exp=1", n_rx0 - rx_b); end
        n_checks++; if (n_irq0 - irq_b !== 1) begin n_fail++; $display("FAIL basic_irq got=%0d exp=1", n_irq0 - irq_b); end
        n_checks++; if ({busy0, oe0, miso0, rdy0} !== 4'b0001) begin n_fail++; $display("FAIL basic_idle got=%b exp=0001", {busy0, oe0, miso0, rdy0}); end
    endtask

    task automatic test_mode3_back_to_back;
        logic [7:0] rd;
        int rx_b;
        rx_b = n_rx3;
        txd3 = 8'h12; txv3 = 1'b1;
        wait_clk(1);
        txv3 = 1'b0;
        ss3 = 1'b0;
        wait_clk(8);
        n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL m3_ready_after_load got=%b exp=1", rdy3); end
        txd3 = 8'h34; txv3 = 1'b1;
        wait_clk(1);
        txv3 = 1'b0;
        xfer(1'b1, 8, 8'hC3, rd);
        n_checks++; if (rd !== 8'h12) begin n_fail++; $display("FAIL m3_miso_1 got=%h exp=12", rd); end
        n_checks++; if (rxd3 !== 8'hC3) begin n_fail++; $display("FAIL m3_rx_1 got=%h exp=c3", rxd3); end
        xfer(1'b1, 8, 8'h5A, rd);
        n_checks++; if (rd !== 8'h34) begin n_fail++; $display("FAIL m3_miso_2 got=%h exp=34", rd); end
        n_checks++; if (rxd3 !== 8'h5A) begin n_fail++; $display("FAIL m3_rx_2 got=%h exp=5a", rxd3); end
        ss3 = 1'b1;
        wait_clk(6);
        n_checks++; if (n_rx3 - rx_b !== 2) begin n_fail++; $display("FAIL m3_rx_count got=%0d exp=2", n_rx3 - rx_b); end
        n_checks++; if (n_irq3 !== n_rx3) begin n_fail++; $display("FAIL m3_irq_count got=%0d exp=%0d", n_irq3, n_rx3); end
        n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL m3_busy got=%b exp=0", busy3); end
    endtask

    task automatic test_abort;
        logic [7:0] rd;
        int rx_b;
`ifdef SPI_SLAVE_ERR_EN
        int fe_b;
        fe_b = n_ferr0;
`endif
        rx_b = n_rx0;
        ss0 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 3, 8'hFF, rd);
        ss0 = 1'b1;
        wait_clk(6);
        n_checks++; if (n_rx0 - rx_b !== 0) begin n_fail++; $display("FAIL abort_rx_valid got=%0d exp=0", n_rx0 - rx_b); end
        n_checks++; if (rxd0 !== 8'h3C) begin n_fail++; $display("FAIL abort_rx_data got=%h exp=3c", rxd0); end
        n_checks++; if ({busy0, oe0, miso0} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got=%b exp=000", {busy0, oe0, miso0}); end
`ifdef SPI_SLAVE_ERR_EN
        n_checks++; if (n_ferr0 - fe_b !== 1) begin n_fail++; $display("FAIL abort_frame_err got=%0d exp=1", n_ferr0 - fe_b); end
`endif
    endtask

    task automatic test_underrun;
        logic [7:0] rd;
        int rx_b;
`ifdef SPI_SLAVE_ERR_EN
        int ur_b;
        ur_b = n_urun0;
`endif
        rx_b = n_rx0;
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL urun_ready_pre got=%b exp=1", rdy0); end
        ss0 = 1'b0;
        wait_clk(2);
        txd0 = 8'h96; txv0 = 1'b1;
        wait_clk(1);
        txv0 = 1'b0;
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL urun_ready_load got=%b exp=0", rdy0); end
        wait_clk(3);
`ifdef SPI_SLAVE_ERR_EN
        n_checks++; if (n_urun0 - ur_b !== 1) begin n_fail++; $display("FAIL urun_pulse got=%0d exp=1", n_urun0 - ur_b); end
`endif
        wait_clk(2);
        xfer(1'b0, 8, 8'h11, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL urun_miso_a got=%h exp=00", rd); end
        xfer(1'b0, 8, 8'h22, rd);
        n_checks++; if (rd !== 8'h96) begin n_fail++; $display("FAIL urun_miso_b got=%h exp=96", rd); end
        ss0 = 1'b1;
        wait_clk(6);
        n_checks++; if (rxd0 !== 8'h22) begin n_fail++; $display("FAIL urun_rx_data got=%h exp=22", rxd0); end
        n_checks++; if (n_rx0 - rx_b !== 2) begin n_fail++; $display("FAIL urun_rx_count got=%0d exp=2", n_rx0 - rx_b); end
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL urun_ready_post got=%b exp=1", rdy0); end
    endtask

    task automatic test_full_ignore;
        logic [7:0] rd;
        push0(8'h5E);
        push0(8'h77);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", rdy0); end
        ss0 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 8, 8'h0F, rd);
        ss0 = 1'b1;
        wait_clk(6);
        n_checks++; if (rd !== 8'h5E) begin n_fail++; $display("FAIL full_miso got=%h exp=5e", rd); end
        n_checks++; if (rxd0 !== 8'h0F) begin n_fail++; $display("FAIL full_rx_data got=%h exp=0f", rxd0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] rd;
        int rx_b;
        push0(8'hC6);
        ss0 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 4, 8'hF0, rd);
        rst = 1'b1;
        ss0 = 1'b1;
        wait_clk(1);
        n_checks++; if ({miso0, oe0, busy0, rdy0, rxv0, irq0} !== 6'b000100) begin n_fail++; $display("FAIL rst_mid_outputs got=%b exp=000100", {miso0, oe0, busy0, rdy0, rxv0, irq0}); end
        n_checks++; if (rxd0 !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx_data got=%h exp=00", rxd0); end
        rst = 1'b0;
        wait_clk(4);
        rx_b = n_rx0;
        push0(8'hE7);
        ss0 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 8, 8'hB4, rd);
        ss0 = 1'b1;
        wait_clk(6);
        n_checks++; if (rd !== 8'hE7) begin n_fail++; $display("FAIL rst_next_miso got=%h exp=e7", rd); end
        n_checks++; if (rxd0 !== 8'hB4) begin n_fail++; $display("FAIL rst_next_rx_data got=%h exp=b4", rxd0); end
        n_checks++; if (n_rx0 - rx_b !== 1) begin n_fail++; $display("FAIL rst_next_rx_count got=%0d exp=1", n_rx0 - rx_b); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mode3_back_to_back;
        test_abort;
        test_underrun;
        test_full_ignore;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
